// File: rtl/u_rca5_adder.sv
// Unsigned ripple-carry adder (HA on bit 0, FA chain above) with a registered WIDTH+1 result.
// Optional macro U_RCA5_ADDER_COMB_OUT_EN exposes the unregistered ripple result on sum_comb.
module u_rca5_adder #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH:0]   out,
  output logic             out_valid
`ifdef U_RCA5_ADDER_COMB_OUT_EN
  ,
  output logic [WIDTH:0]   sum_comb
`endif
);

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   r_out;
  logic             r_out_valid;

  // Stage 0: combinational ripple chain, carry flows LSB to MSB
  assign w_s[0] = a[0] ^ b[0];
  assign w_c[0] = a[0] & b[0];

  generate
    for (genvar i = 1; i < WIDTH; i++) begin : g_fa
      logic w_p;
      assign w_p    = a[i] ^ b[i];
      assign w_s[i] = w_p ^ w_c[i-1];
      assign w_c[i] = (a[i] & b[i]) | (w_c[i-1] & w_p);
    end
  endgenerate

  assign w_sum = {w_c[WIDTH-1], w_s};

  // Stage 1: result register; capture is gated by in_valid so X operands on idle cycles never reach out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_sum;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

`ifdef U_RCA5_ADDER_COMB_OUT_EN
  assign sum_comb = w_sum;
`endif

endmodule

// File: tb/tb_u_rca5_adder.sv
// Self-checking bench for u_rca5_adder: directed cases, a structured stream and random traffic
// compared against an arithmetic reference model.
module tb_u_rca5_adder;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH:0]   out;
  logic             out_valid;
`ifdef U_RCA5_ADDER_COMB_OUT_EN
  logic [WIDTH:0]   sum_comb;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  int exp_out = 0;
  int exp_vld = 0;

  u_rca5_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
`ifdef U_RCA5_ADDER_COMB_OUT_EN
    ,
    .sum_comb  (sum_comb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out"}, {26'd0, out}, exp_out);
    chk({tag, ".vld"}, {31'd0, out_valid}, exp_vld);
  endtask

  // drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input int av, input int bv, input bit v, input string tag);
    @(negedge clk);
    a        = av[WIDTH-1:0];
    b        = bv[WIDTH-1:0];
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) begin
      exp_out = (av % 32) + (bv % 32);
      exp_vld = 1;
    end else begin
      exp_vld = 0;
    end
    check_outputs(tag);
  endtask

  initial begin
    int sa;
    int sb;
    rst      = 1'b1;
    a        = '0;
    b        = '0;
    in_valid = 1'b0;
    #2;
    chk("reset.out", {26'd0, out}, 0);
    chk("reset.vld", {31'd0, out_valid}, 0);

    // in_valid is ignored while reset is held
    @(negedge clk);
    a = 5'd7; b = 5'd9; in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_hold.out", {26'd0, out}, 0);
    chk("rst_hold.vld", {31'd0, out_valid}, 0);

    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    step(4, 20, 1'b1, "first_4p20");
    chk("first.value", {26'd0, out}, 24);
    step(31, 31, 1'b1, "max_31p31");
    chk("max.carry", {31'd0, out[5]}, 1);
    chk("max.sum", {27'd0, out[4:0]}, 30);
    step(31, 1, 1'b1, "ripple_31p1");
    step(0, 0, 1'b1, "zero_0p0");

    // valid toggling: capture, hold (with X operands), capture
    step(6, 23, 1'b1, "tog1");
    @(negedge clk);
    a = 'x; b = 'x; in_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_vld = 0;
    check_outputs("tog_hold_x");
    chk("tog_hold.value", {26'd0, out}, 29);
    step(10, 26, 1'b1, "tog2");
    chk("tog2.value", {26'd0, out}, 36);

    // structured stream: a += 2 every cycle, b += 3 every second cycle
    sa = 4;
    sb = 20;
    for (int i = 0; i < 100; i++) begin
      step(sa, sb, 1'b1, "stream");
      sa = (sa + 2) % 32;
      if (i % 2 == 1) sb = (sb + 3) % 32;
    end

    // random traffic with random valid
    for (int i = 0; i < 200; i++) begin
      step(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           bit'($urandom_range(0, 1)), "random");
    end

    // asynchronous reset between edges
    step(17, 13, 1'b1, "pre_rst");
    @(negedge clk);
    a = 5'd12; b = 5'd19; in_valid = 1'b1;
    rst = 1'b1;
    #1;
    exp_out = 0;
    exp_vld = 0;
    check_outputs("async_rst");
`ifdef U_RCA5_ADDER_COMB_OUT_EN
    chk("async_rst.comb", {26'd0, sum_comb}, 31);
`endif
    @(posedge clk);
    #1;
    check_outputs("async_rst_edge");
    @(negedge clk);
    rst = 1'b0;
    step(25, 9, 1'b1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
